// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, one-slave arbiter in front of the memory mapper.
// Master 0 is the CPU/MMU physical port, master 1 is the secondary bus master.
// Grants are fixed-priority or round-robin, and a watchdog force-completes a
// transaction whose slave never answers.
module bus_arbiter #(
    parameter int          ROUND_ROBIN    = 1,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
    parameter int          CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic [1:0]  grant,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } StateType;

    // Counter value seen in the last cycle a grant may last before the watchdog fires.
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    StateType         r_state;
    StateType         w_nextState;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic             w_req0;
    logic             w_req1;
    logic             w_granted;
    logic             w_timeout;
    logic             w_done;
    logic             w_readyOut;
    logic [31:0]      w_spoOut;

    assign w_req0    = m0_we | m0_rd;
    assign w_req1    = m1_we | m1_rd;
    assign w_granted = (r_state == GNT0) || (r_state == GNT1);

    // A real slave answer always beats the watchdog when both land in the same cycle.
    assign w_timeout  = TIMEOUT_EN && w_granted && !s_ready && (r_cnt == CNT_LAST);
    assign w_done     = w_granted && (s_ready || w_timeout);
    assign w_readyOut = s_ready || w_timeout;
    assign w_spoOut   = w_timeout ? TIMEOUT_DATA : s_spo;

    assign err = r_err;

    // State register; reset always returns the bus to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Bookkeeping: watchdog counter, last owner for round-robin, and the err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (!w_granted) begin
                r_cnt <= '0;
            end else if (!w_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_last <= (r_state == GNT1);
            end
        end
    end

    // Next-state: arbitrate from idle, hold the grant until completion or timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_req0 && w_req1) begin
                    if ((ROUND_ROBIN != 0) && !r_last) begin
                        w_nextState = GNT1;
                    end else begin
                        w_nextState = GNT0;
                    end
                end else if (w_req0) begin
                    w_nextState = GNT0;
                end else if (w_req1) begin
                    w_nextState = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (w_done) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output mux: forward the owner to the slave; outputs stay quiet while in reset.
    always_comb begin
        s_a      = '0;
        s_d      = '0;
        s_we     = 1'b0;
        s_rd     = 1'b0;
        m0_spo   = '0;
        m0_ready = 1'b0;
        m1_spo   = '0;
        m1_ready = 1'b0;
        grant    = 2'b00;
        if (!rst) begin
            case (r_state)
                GNT0: begin
                    s_a      = m0_a;
                    s_d      = m0_d;
                    s_we     = m0_we;
                    s_rd     = m0_rd;
                    m0_spo   = w_spoOut;
                    m0_ready = w_readyOut;
                    grant    = 2'b01;
                end
                GNT1: begin
                    s_a      = m1_a;
                    s_d      = m1_d;
                    s_we     = m1_we;
                    s_rd     = m1_rd;
                    m1_spo   = w_spoOut;
                    m1_ready = w_readyOut;
                    grant    = 2'b10;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed stimulus with a completion scoreboard for bus_arbiter.
// Two instances share the master inputs: a round-robin one with a short watchdog
// and a fixed-priority one; an enable per instance decides which sees requests.
module tb_bus_arbiter;

    typedef struct {
        int          master;
        logic [31:0] spo;
        int          cyc;
    } ExpEntry;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_a, m0_d, m1_a, m1_d;
    logic        m0_we, m0_rd, m1_we, m1_rd;
    logic        rrEn, fixEn;

    int          slaveLat;
    logic [31:0] slaveData;
    int          sCnt  = 0;
    int          cycle = 0;

    int          checks = 0;
    int          errors = 0;

    ExpEntry     rrQ[$];
    ExpEntry     fixQ[$];
    int          errQ[$];
    ExpEntry     e;
    int          got;
    int          c;

    logic [31:0] rrM0Spo, rrM1Spo, rrSA, rrSD;
    logic        rrM0Ready, rrM1Ready, rrSWe, rrSRd, rrSReady, rrErr;
    logic [1:0]  rrGrant;
    logic [31:0] fixM0Spo, fixM1Spo, fixSA, fixSD;
    logic        fixM0Ready, fixM1Ready, fixSWe, fixSRd, fixSReady, fixErr;
    logic [1:0]  fixGrant;

    always #5 clk = ~clk;

    // Cycle counter plus the round-robin instance's slave: answers after slaveLat strobe cycles.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        sCnt  <= ((rrSWe || rrSRd) && !rrSReady) ? sCnt + 1 : 0;
    end

    assign rrSReady  = (rrSWe || rrSRd) && (sCnt == slaveLat);
    assign fixSReady = fixSWe || fixSRd;

    bus_arbiter #(
        .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEADBEEF), .CNT_W(4)
    ) dutRr (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we & rrEn), .m0_rd(m0_rd & rrEn),
        .m0_spo(rrM0Spo), .m0_ready(rrM0Ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we & rrEn), .m1_rd(m1_rd & rrEn),
        .m1_spo(rrM1Spo), .m1_ready(rrM1Ready),
        .s_a(rrSA), .s_d(rrSD), .s_we(rrSWe), .s_rd(rrSRd),
        .s_spo(slaveData), .s_ready(rrSReady),
        .grant(rrGrant), .err(rrErr)
    );

    bus_arbiter #(
        .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEADBEEF), .CNT_W(4)
    ) dutFix (
        .clk(clk), .rst(rst),
        .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we & fixEn), .m0_rd(m0_rd & fixEn),
        .m0_spo(fixM0Spo), .m0_ready(fixM0Ready),
        .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we & fixEn), .m1_rd(m1_rd & fixEn),
        .m1_spo(fixM1Spo), .m1_ready(fixM1Ready),
        .s_a(fixSA), .s_d(fixSD), .s_we(fixSWe), .s_rd(fixSRd),
        .s_spo(slaveData), .s_ready(fixSReady),
        .grant(fixGrant), .err(fixErr)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we0, input logic rd0, input logic [31:0] a0,
                                 input logic we1, input logic rd1, input logic [31:0] a1);
        m0_we = we0; m0_rd = rd0; m0_a = a0; m0_d = a0 ^ 32'h0F0F_0F0F;
        m1_we = we1; m1_rd = rd1; m1_a = a1; m1_d = a1 ^ 32'hF0F0_F0F0;
    endtask

    task automatic expectRr(input int master, input logic [31:0] spo, input int cyc);
        ExpEntry x;
        x.master = master; x.spo = spo; x.cyc = cyc;
        rrQ.push_back(x);
    endtask

    task automatic expectFix(input int master, input logic [31:0] spo, input int cyc);
        ExpEntry x;
        x.master = master; x.spo = spo; x.cyc = cyc;
        fixQ.push_back(x);
    endtask

    // Monitor on the round-robin instance: every ready pulse must match the head of the queue.
    task automatic monitorRr();
        if (rrM0Ready && rrM1Ready) begin
            checks++; errors++;
            $display("[TB] FAIL rrBothReady: both readies high at cycle %0d, expected at most one", cycle);
        end else if (rrM0Ready || rrM1Ready) begin
            got = rrM1Ready ? 1 : 0;
            if (rrQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL rrUnexpectedReady: master %0d ready at cycle %0d, expected none", got, cycle);
            end else begin
                e = rrQ.pop_front();
                checkOutput("rrMaster", 32'(got), 32'(e.master));
                checkOutput("rrSpo", got == 1 ? rrM1Spo : rrM0Spo, e.spo);
                checkOutput("rrCycle", 32'(cycle), 32'(e.cyc));
                checkOutput("rrGrantAtReady", 32'(rrGrant), 32'(1 << e.master));
                checkOutput("rrOtherSpo", got == 1 ? rrM0Spo : rrM1Spo, 32'h0);
            end
        end
        if (rrErr) begin
            if (errQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL rrUnexpectedErr: err high at cycle %0d, expected low", cycle);
            end else begin
                checkOutput("rrErrCycle", 32'(cycle), 32'(errQ.pop_front()));
            end
        end
    endtask

    // Monitor on the fixed-priority instance; it has no timeouts so err must stay low.
    task automatic monitorFix();
        if (fixM0Ready || fixM1Ready) begin
            got = fixM1Ready ? 1 : 0;
            if (fixQ.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL fixUnexpectedReady: master %0d ready at cycle %0d, expected none", got, cycle);
            end else begin
                e = fixQ.pop_front();
                checkOutput("fixMaster", 32'(got), 32'(e.master));
                checkOutput("fixSpo", got == 1 ? fixM1Spo : fixM0Spo, e.spo);
                checkOutput("fixCycle", 32'(cycle), 32'(e.cyc));
            end
        end
        if (fixErr) begin
            checks++; errors++;
            $display("[TB] FAIL fixUnexpectedErr: err high at cycle %0d, expected low", cycle);
        end
    endtask

    initial begin
        rst = 1'b1; rrEn = 1'b1; fixEn = 1'b0;
        slaveLat = 0; slaveData = 32'h0;
        applyStimulus(1'b0, 1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0);

        fork
            forever begin
                @(negedge clk);
                monitorRr();
                monitorFix();
            end
        join_none

        // Reset state with a pending request: everything must stay quiet.
        waitCycles(2);
        checkOutput("rstGrant", 32'(rrGrant), 32'h0);
        checkOutput("rstSRd", 32'(rrSRd), 32'h0);
        checkOutput("rstSWe", 32'(rrSWe), 32'h0);
        checkOutput("rstSA", rrSA, 32'h0);
        checkOutput("rstSD", rrSD, 32'h0);
        checkOutput("rstM0Spo", rrM0Spo, 32'h0);
        checkOutput("rstErr", 32'(rrErr), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        waitCycles(2);

        // Contested round-robin straight out of reset: m0 first, then strict alternation.
        c = cycle;
        slaveLat = 0; slaveData = 32'h600D_D00D;
        applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            expectRr(0, 32'h600D_D00D, c + 1 + 4 * i);
            expectRr(1, 32'h600D_D00D, c + 3 + 4 * i);
        end
        waitCycles(1); checkOutput("rrSeq0", 32'(rrGrant), 32'h1);
        waitCycles(1); checkOutput("rrSeq1", 32'(rrGrant), 32'h0);
        waitCycles(1); checkOutput("rrSeq2", 32'(rrGrant), 32'h2);
        checkOutput("rrSeq2Addr", rrSA, 32'h0000_0200);
        waitCycles(1); checkOutput("rrSeq3", 32'(rrGrant), 32'h0);
        waitCycles(6); m0_rd = 1'b0;
        waitCycles(2); m1_rd = 1'b0;
        waitCycles(2);

        // Single m0 read, slave answers one cycle after the strobe.
        c = cycle;
        slaveLat = 1; slaveData = 32'h1234_5678;
        applyStimulus(1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0);
        expectRr(0, 32'h1234_5678, c + 2);
        checkOutput("readArbCycle", 32'(rrGrant), 32'h0);
        waitCycles(1);
        checkOutput("readGrant", 32'(rrGrant), 32'h1);
        checkOutput("readSRd", 32'(rrSRd), 32'h1);
        checkOutput("readSA", rrSA, 32'h0000_1000);
        checkOutput("readEarlyReady", 32'(rrM0Ready), 32'h0);
        waitCycles(2);
        m0_rd = 1'b0;
        checkOutput("readIdleAfter", 32'(rrGrant), 32'h0);
        waitCycles(2);

        // Write from m1 to a slave that never answers: watchdog completes it.
        c = cycle;
        slaveLat = 1000; slaveData = 32'h1111_2222;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_3000);
        expectRr(1, 32'hDEAD_BEEF, c + 8);
        errQ.push_back(c + 9);
        waitCycles(1);
        checkOutput("toGrant", 32'(rrGrant), 32'h2);
        checkOutput("toSWe", 32'(rrSWe), 32'h1);
        checkOutput("toSA", rrSA, 32'h0000_3000);
        checkOutput("toSD", rrSD, 32'h0000_3000 ^ 32'hF0F0_F0F0);
        waitCycles(8);
        m1_we = 1'b0;
        checkOutput("toIdleAfter", 32'(rrGrant), 32'h0);
        waitCycles(2);

        // Slave answers in the same cycle the watchdog would fire: normal completion.
        c = cycle;
        slaveLat = 7; slaveData = 32'h0BAD_F00D;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3004);
        expectRr(1, 32'h0BAD_F00D, c + 8);
        waitCycles(9);
        m1_rd = 1'b0;
        waitCycles(2);

        // Reset in the middle of an m0 grant; the held request is granted again afterwards.
        c = cycle;
        slaveLat = 1000; slaveData = 32'h55AA_55AA;
        applyStimulus(1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
        waitCycles(1);
        checkOutput("midGrant", 32'(rrGrant), 32'h1);
        checkOutput("midSRd", 32'(rrSRd), 32'h1);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midRstSRd", 32'(rrSRd), 32'h0);
        checkOutput("midRstSWe", 32'(rrSWe), 32'h0);
        checkOutput("midRstGrant", 32'(rrGrant), 32'h0);
        checkOutput("midRstReady", 32'(rrM0Ready), 32'h0);
        slaveLat = 1;
        rst = 1'b0;
        expectRr(0, 32'h55AA_55AA, c + 4);
        waitCycles(1);
        checkOutput("midRegrant", 32'(rrGrant), 32'h1);
        waitCycles(2);
        m0_rd = 1'b0;
        waitCycles(2);

        // Fixed priority: m0 keeps winning; m1 only gets the bus once m0 lets go.
        rrEn = 1'b0; fixEn = 1'b1;
        c = cycle;
        slaveData = 32'h7777_7777;
        applyStimulus(1'b0, 1'b1, 32'h0000_4000, 1'b0, 1'b1, 32'h0000_5000);
        expectFix(0, 32'h7777_7777, c + 1);
        expectFix(0, 32'h7777_7777, c + 3);
        expectFix(0, 32'h7777_7777, c + 5);
        expectFix(1, 32'h7777_7777, c + 7);
        waitCycles(3);
        checkOutput("fixGrantM0", 32'(fixGrant), 32'h1);
        waitCycles(3); m0_rd = 1'b0;
        waitCycles(2); m1_rd = 1'b0;
        waitCycles(5);

        checkOutput("rrQueueDrained", 32'(rrQ.size()), 32'h0);
        checkOutput("fixQueueDrained", 32'(fixQ.size()), 32'h0);
        checkOutput("errQueueDrained", 32'(errQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
